// File: rtl/serial_pkg.sv
// Shared serial-link types: FSM state encoding and default word width.
// Imported by the PISO transmitter and the downstream SISO stage.
package serial_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-in handshake plus serial-out bundle for piso_serializer.
// The slave modport is the serializer; master is whoever feeds it.
interface piso_serializer_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with optional inter-word gap.
// Every output is a flop, so nothing combinational reaches din/din_valid.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  piso_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int OB = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CW-1:0] BLAST = CW'(WIDTH - 1);
  localparam logic [3:0] GLOAD =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [3:0]       gcnt_q, gcnt_d;

  logic sout_q, sout_d;
  logic sv_q, sv_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic rdy_q, rdy_d;
  logic accept;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    accept  = bus.din_valid && rdy_q;

    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        if (MSB_FIRST) sr_d = sr_q << 1;
        else           sr_d = sr_q >> 1;
        bcnt_d = bcnt_q - CW'(1);
        if (bcnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gcnt_d  = GLOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gcnt_d = gcnt_q - 4'd1;
        if (gcnt_q == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A handshake overrides the last-bit exit, giving back-to-back words
    if (accept) begin
      sr_d    = bus.din;
      bcnt_d  = BLAST;
      state_d = SHIFT;
    end

    sv_d   = (state_d == SHIFT);
    sout_d = sv_d ? sr_d[OB] : IDLE_LEVEL;
    busy_d = (state_d != IDLE);
    done_d = sv_d && (bcnt_d == '0);
    rdy_d  = (state_d == IDLE) ||
             ((GAP_CYCLES == 0) && done_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      sout_q  <= IDLE_LEVEL;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      sout_q  <= sout_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.din_ready  = rdy_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sv_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB/gap0, MSB/gap0 and LSB/gap3 instances
// plus a 4-bit shift-right SISO model on the LSB-first output.
module tb_piso_serializer;
  import serial_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int NR = 300;
  localparam int NA = NR + 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]   vld;
  logic [W-1:0] dat [3];

  piso_serializer_if #(.WIDTH(W)) b0 ();
  piso_serializer_if #(.WIDTH(W)) b1 ();
  piso_serializer_if #(.WIDTH(W)) b2 ();

  assign b0.din = dat[0];
  assign b1.din = dat[1];
  assign b2.din = dat[2];
  assign b0.din_valid = vld[0];
  assign b1.din_valid = vld[1];
  assign b2.din_valid = vld[2];

  piso_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b0),
    .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)
  ) u0 (.clk(clk), .rst(rst), .bus(b0.slave));

  piso_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b1),
    .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)
  ) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  piso_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b0),
    .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)
  ) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  wire [2:0] o_rdy = {b2.din_ready, b1.din_ready, b0.din_ready};
  wire [2:0] o_so  = {b2.sout, b1.sout, b0.sout};
  wire [2:0] o_sv  = {b2.sout_valid, b1.sout_valid, b0.sout_valid};
  wire [2:0] o_bz  = {b2.busy, b1.busy, b0.busy};
  wire [2:0] o_dn  = {b2.done, b1.done, b0.done};

  logic [W-1:0] siso_q;
  always @(posedge clk) siso_q <= {b0.sout, siso_q[W-1:1]};

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input int i, input string tag,
                         input bit ev, input bit es, input bit ed);
    chk($sformatf("%s u%0d sout_valid", tag, i), 32'(o_sv[i]), 32'(ev));
    chk($sformatf("%s u%0d sout", tag, i), 32'(o_so[i]), 32'(es));
    chk($sformatf("%s u%0d done", tag, i), 32'(o_dn[i]), 32'(ed));
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] lsb_seq;
    logic [W-1:0] msb_seq;
  } vec_t;

  vec_t tbl [5];

  int gap_of [3] = '{0, 0, 3};
  bit msb_of [3] = '{1'b0, 1'b1, 1'b0};

  bit m_sv [3][NA];
  bit m_so [3][NA];
  bit m_dn [3][NA];
  bit m_bz [3][NA];
  int free_at [3];

  logic [W-1:0] sq;
  logic [7:0]   s8a, s8b;
  logic [0:12]  p_sv, p_so, p_dn, p_bz, p_rd;

  initial begin
    tbl[0] = '{4'b1011, 4'b1101, 4'b1011};
    tbl[1] = '{4'b1000, 4'b0001, 4'b1000};
    tbl[2] = '{4'b0011, 4'b1100, 4'b0011};
    tbl[3] = '{4'b0110, 4'b0110, 4'b0110};
    tbl[4] = '{4'b1110, 4'b0111, 4'b1110};

    vld = 3'b111;
    for (int i = 0; i < 3; i++) dat[i] = 4'hF;
    #1 rst = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst sout", 32'(o_so), 0);
      chk("rst sout_valid", 32'(o_sv), 0);
      chk("rst din_ready", 32'(o_rdy), 0);
      chk("rst busy_done", 32'({o_bz, o_dn}), 0);
    end
    vld = 3'b000;
    rst = 1'b1;
    #1 chk("release ready before edge", 32'(o_rdy), 0);
    @(negedge clk);
    chk("release ready after edge", 32'(o_rdy), 32'(3'b111));

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      vld = 3'b111;
      for (int i = 0; i < 3; i++) dat[i] = tbl[v].din;
      for (int c = 0; c < W; c++) begin
        @(negedge clk);
        if (c == 0) begin
          vld = 3'b000;
          for (int i = 0; i < 3; i++) dat[i] = ~tbl[v].din;
        end
        for (int i = 0; i < 3; i++) begin
          sq = msb_of[i] ? tbl[v].msb_seq : tbl[v].lsb_seq;
          chk_bit(i, $sformatf("tbl%0d c%0d", v, c),
                  1'b1, sq[W-1-c], c == W - 1);
        end
        chk($sformatf("tbl%0d c%0d u2 busy", v, c), 32'(o_bz[2]), 1);
      end
      @(negedge clk);
      chk($sformatf("tbl%0d siso q", v), 32'(siso_q), 32'(tbl[v].din));
      chk($sformatf("tbl%0d u0 after", v), 32'(o_sv[0]), 0);
      chk($sformatf("tbl%0d u0 ready", v), 32'(o_rdy[0]), 1);
      for (int g = 0; g < 3; g++) begin
        if (g > 0) @(negedge clk);
        chk($sformatf("tbl%0d gap%0d u2 sv/rdy/bz/so", v, g),
            32'({o_sv[2], o_rdy[2], o_bz[2], o_so[2]}), 32'(4'b0010));
      end
      @(negedge clk);
      chk($sformatf("tbl%0d u2 idle rdy/bz", v),
          32'({o_rdy[2], o_bz[2]}), 32'(2'b10));
    end

    // Back-to-back on the gapless instances: 4'hA then 4'h5
    s8a = 8'b0101_1010;
    s8b = 8'b1010_0101;
    @(negedge clk);
    vld[1:0] = 2'b11;
    dat[0] = 4'hA;
    dat[1] = 4'hA;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        dat[0] = 4'h5;
        dat[1] = 4'h5;
      end
      if (c == 4) vld[1:0] = 2'b00;
      chk_bit(0, $sformatf("b2b c%0d", c), 1'b1, s8a[7-c],
              c == 3 || c == 7);
      chk_bit(1, $sformatf("b2b c%0d", c), 1'b1, s8b[7-c],
              c == 3 || c == 7);
      if (c == 1) chk("b2b mid ready", 32'(o_rdy[1:0]), 0);
      if (c == 3) chk("b2b last ready", 32'(o_rdy[1:0]), 32'(2'b11));
    end
    @(negedge clk);
    chk("b2b end valid", 32'(o_sv[1:0]), 0);

    // Gap instance: words held valid, second waits out the 3-cycle gap
    p_sv = 13'b1111_0000_1111_0;
    p_so = 13'b0101_0000_1010_0;
    p_dn = 13'b0001_0000_0001_0;
    p_bz = 13'b1111_1110_1111_1;
    p_rd = 13'b0000_0001_0000_0;
    @(negedge clk);
    vld[2] = 1'b1;
    dat[2] = 4'hA;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 0) dat[2] = 4'h5;
      if (c == 8) vld[2] = 1'b0;
      chk_bit(2, $sformatf("gap c%0d", c), p_sv[c], p_so[c], p_dn[c]);
      chk($sformatf("gap c%0d busy", c), 32'(o_bz[2]), 32'(p_bz[c]));
      chk($sformatf("gap c%0d ready", c), 32'(o_rdy[2]), 32'(p_rd[c]));
    end
    repeat (4) @(negedge clk);

    // Reset in the middle of a word
    vld[0] = 1'b1;
    dat[0] = 4'b1011;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("mid bit0 valid", 32'(o_sv[0]), 1);
    @(negedge clk);
    chk("mid bit1 valid", 32'(o_sv[0]), 1);
    #1 rst = 1'b0;
    #1;
    chk("mid async sout", 32'(o_so[0]), 0);
    chk("mid async sout_valid", 32'(o_sv[0]), 0);
    chk("mid async done", 32'(o_dn[0]), 0);
    repeat (2) begin
      @(posedge clk);
      #1 chk("mid held done/valid", 32'({o_dn, o_sv}), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid post ready", 32'(o_rdy), 32'(3'b111));
    vld[0] = 1'b1;
    dat[0] = 4'h3;
    sq = 4'b1100;
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      if (c == 0) vld[0] = 1'b0;
      chk_bit(0, $sformatf("mid new c%0d", c), 1'b1, sq[W-1-c],
              c == W - 1);
    end
    @(negedge clk);
    chk("mid new siso q", 32'(siso_q), 32'(4'h3));
    chk("mid new end valid", 32'(o_sv[0]), 0);

    // Random traffic against a timeline model of the word schedule
    @(negedge clk);
    rst = 1'b0;
    vld = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      free_at[i] = 0;
      for (int k = 0; k < NA; k++) begin
        m_sv[i][k] = 1'b0;
        m_so[i][k] = 1'b0;
        m_dn[i][k] = 1'b0;
        m_bz[i][k] = 1'b0;
      end
    end
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk_bit(i, $sformatf("rnd k%0d", k),
                m_sv[i][k], m_so[i][k], m_dn[i][k]);
        chk($sformatf("rnd k%0d u%0d busy", k, i),
            32'(o_bz[i]), 32'(m_bz[i][k]));
        chk($sformatf("rnd k%0d u%0d ready", k, i),
            32'(o_rdy[i]), 32'(k >= free_at[i]));
        vld[i] = ($urandom % 4) != 0;
        dat[i] = W'($urandom);
        if (vld[i] && k >= free_at[i]) begin
          for (int j = 0; j < W; j++) begin
            m_sv[i][k+1+j] = 1'b1;
            m_bz[i][k+1+j] = 1'b1;
            m_so[i][k+1+j] = msb_of[i] ? dat[i][W-1-j] : dat[i][j];
          end
          m_dn[i][k+W] = 1'b1;
          for (int g = 1; g <= gap_of[i]; g++) m_bz[i][k+W+g] = 1'b1;
          free_at[i] = k + W + gap_of[i] + ((gap_of[i] > 0) ? 1 : 0);
        end
      end
    end
    vld = 3'b000;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
